// File: rtl/f1_round_engine.sv
// Iterative F1 round engine: key XOR plus fixed per-lane byte rotation, applied ROUNDS times.
// Runs forward (encrypt) or exact inverse (decrypt), with valid/ready on data-in, round key and data-out.
module f1_round_engine #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned ROUNDS = 8,
    parameter logic [3*NBYTES-1:0] ROT = {3'd5, 3'd4, 3'd1, 3'd0},
    localparam int unsigned W  = 8 * NBYTES,
    localparam int unsigned CW = $clog2(ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_mode,
    input  logic          rk_valid,
    output logic          rk_ready,
    input  logic [W-1:0]  rk_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] round_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0] blk;
    logic         dec;
    logic [W-1:0] round_y;
    logic         accept;
    logic         consume;
    logic         last;

    logic [2:0]  rot_amt;
    logic [7:0]  x_lane;
    logic [7:0]  k_lane;
    logic [7:0]  t_lane;
    logic [15:0] dbl;

    assign last = (round_idx == CW'(ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        rk_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                rk_ready = 1'b1;
                if (rk_valid && last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Reset blocks both handshakes in the cycle it is asserted.
        if (rst) begin
            in_ready = 1'b0;
            rk_ready = 1'b0;
        end
    end

    assign accept  = in_ready && in_valid;
    assign consume = rk_ready && rk_valid;

    // Lane 0 is the most significant byte; its rotate amount is the leftmost ROT field.
    always_comb begin
        round_y = '0;
        rot_amt = '0;
        x_lane  = '0;
        k_lane  = '0;
        t_lane  = '0;
        dbl     = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            rot_amt = ROT[3*(NBYTES-1-i) +: 3];
            x_lane  = blk[8*(NBYTES-1-i) +: 8];
            k_lane  = rk_data[8*(NBYTES-1-i) +: 8];
            if (!dec) begin
                t_lane = x_lane ^ k_lane;
                dbl    = {t_lane, t_lane} << rot_amt;
                round_y[8*(NBYTES-1-i) +: 8] = dbl[15:8];
            end else begin
                dbl    = {x_lane, x_lane} >> rot_amt;
                round_y[8*(NBYTES-1-i) +: 8] = dbl[7:0] ^ k_lane;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk       <= '0;
            dec       <= 1'b0;
            round_idx <= '0;
            out_data  <= '0;
        end else if (accept) begin
            blk       <= in_data;
            dec       <= in_mode;
            round_idx <= '0;
        end else if (consume) begin
            blk       <= round_y;
            round_idx <= round_idx + CW'(1);
            if (last) out_data <= round_y;
        end
    end

endmodule

// File: tb/tb_f1_round_engine.sv
// Self-checking bench for f1_round_engine: three instances (1 round, 8 rounds, 8-byte/4-round)
// checked against a lane-by-lane arithmetic reference model.
module tb_f1_round_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    int rot4[8] = '{5, 4, 1, 0, 0, 0, 0, 0};
    int rotw[8] = '{0, 1, 2, 3, 4, 5, 6, 7};

    // 8-round, 4-byte instance
    logic        a_rst, a_in_valid, a_in_ready, a_in_mode, a_rk_valid, a_rk_ready;
    logic        a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_rk_data, a_out_data;
    logic [3:0]  a_round_idx;

    // 1-round, 4-byte instance
    logic        rst, s_in_valid, s_in_ready, s_in_mode, s_rk_valid, s_rk_ready;
    logic        s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_rk_data, s_out_data;
    logic [0:0]  s_round_idx;

    // 4-round, 8-byte instance
    logic        w_in_valid, w_in_ready, w_in_mode, w_rk_valid, w_rk_ready;
    logic        w_out_valid, w_out_ready;
    logic [63:0] w_in_data, w_rk_data, w_out_data;
    logic [2:0]  w_round_idx;

    f1_round_engine #(.NBYTES(4), .ROUNDS(8)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_mode(a_in_mode), .rk_valid(a_rk_valid), .rk_ready(a_rk_ready),
        .rk_data(a_rk_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .round_idx(a_round_idx)
    );

    f1_round_engine #(.NBYTES(4), .ROUNDS(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_mode(s_in_mode), .rk_valid(s_rk_valid), .rk_ready(s_rk_ready),
        .rk_data(s_rk_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .round_idx(s_round_idx)
    );

    f1_round_engine #(
        .NBYTES(8),
        .ROUNDS(4),
        .ROT({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7})
    ) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_data(w_in_data), .in_mode(w_in_mode), .rk_valid(w_rk_valid), .rk_ready(w_rk_ready),
        .rk_data(w_rk_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_data(w_out_data), .round_idx(w_round_idx)
    );

    // Reference: each round treats the block as nb bytes (lane 0 = most significant byte).
    function automatic logic [63:0] model_block(input logic [63:0] x, input logic inv,
                                                input logic [63:0] kk[8], input int nb,
                                                input int nr, input int rot[8]);
        logic [63:0] v;
        logic [63:0] nv;
        int sh, b, kb, r, t, y;
        v = x;
        for (int n = 0; n < nr; n++) begin
            nv = 64'd0;
            for (int i = 0; i < nb; i++) begin
                sh = 8 * (nb - 1 - i);
                b  = int'((v >> sh) & 64'hFF);
                kb = int'((kk[n] >> sh) & 64'hFF);
                r  = rot[i] % 8;
                if (!inv) begin
                    t = b ^ kb;
                    y = ((t << r) | (t >> (8 - r))) & 255;
                end else begin
                    y = (((b >> r) | (b << (8 - r))) & 255) ^ kb;
                end
                nv = nv | (64'(y) << sh);
            end
            v = nv;
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Feeds keys in order until out_valid; optional stall after stall_at keys, optional busy jamming.
    task automatic r8_finish(input logic [63:0] kk[8], input int stall_at, input int stall_len,
                             input bit jam, output int lat);
        int ptr;
        int stalled;
        bit consume;
        ptr = 0;
        stalled = 0;
        lat = 0;
        while (!a_out_valid && lat < 64) begin
            a_rk_valid = !(ptr == stall_at && stalled < stall_len);
            if (!a_rk_valid) stalled++;
            a_rk_data = kk[ptr < 8 ? ptr : 7][31:0];
            if (jam) begin
                a_in_valid = 1'b1;
                a_in_data  = $urandom;
                a_in_mode  = 1'($urandom_range(0, 1));
                total++;
                if (a_in_ready !== 1'b0) $display("FAIL busy_in_ready: got %b expected 0", a_in_ready);
                else pass_cnt++;
            end
            consume = a_rk_valid && a_rk_ready;
            tick;
            lat++;
            if (consume) ptr++;
            total++;
            if (a_round_idx !== 4'(ptr)) $display("FAIL round_idx: got %0d expected %0d", a_round_idx, ptr);
            else pass_cnt++;
        end
        a_rk_valid = 1'b1;
        if (lat >= 64) begin
            total++;
            $display("FAIL r8_timeout: out_valid never rose, got 0 expected 1");
        end
    endtask

    task automatic r8_run(input logic [31:0] data, input logic mode, input logic [63:0] kk[8],
                          input int stall_at, input int stall_len, input int hold,
                          output logic [31:0] result, output int lat);
        int n;
        a_in_valid  = 1'b1;
        a_in_data   = data;
        a_in_mode   = mode;
        a_out_ready = 1'b0;
        n = 0;
        while (!a_in_ready && n < 40) begin tick; n++; end
        if (n >= 40) begin
            total++;
            $display("FAIL r8_accept_timeout: in_ready got 0 expected 1");
        end
        tick;
        a_in_valid = 1'b0;
        a_in_data  = ~data;
        a_in_mode  = !mode;
        r8_finish(kk, stall_at, stall_len, 1'b0, lat);
        result = a_out_data;
        total++;
        if (a_rk_ready !== 1'b0) $display("FAIL rk_ready_done: got %b expected 0", a_rk_ready);
        else pass_cnt++;
        for (int h = 0; h < hold; h++) begin
            a_in_valid = 1'b1;
            a_in_data  = $urandom;
            tick;
            total++;
            if (a_out_valid !== 1'b1 || a_out_data !== result || a_in_ready !== 1'b0)
                $display("FAIL hold: got v=%b d=%h ir=%b expected v=1 d=%h ir=0",
                         a_out_valid, a_out_data, a_in_ready, result);
            else pass_cnt++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;
        total++;
        if (a_out_valid !== 1'b0) $display("FAIL out_valid_clear: got %b expected 0", a_out_valid);
        else pass_cnt++;
    endtask

    task automatic w_run(input logic [63:0] data, input logic mode, input logic [63:0] kk[8],
                         output logic [63:0] result);
        int n;
        int ptr;
        bit consume;
        w_in_valid = 1'b1;
        w_in_data  = data;
        w_in_mode  = mode;
        n = 0;
        while (!w_in_ready && n < 20) begin tick; n++; end
        tick;
        w_in_valid = 1'b0;
        w_in_data  = {$urandom, $urandom};
        w_in_mode  = !mode;
        ptr = 0;
        n = 0;
        while (!w_out_valid && n < 100) begin
            w_rk_valid = ($urandom_range(0, 3) != 0);
            w_rk_data  = kk[ptr < 4 ? ptr : 3];
            consume = w_rk_valid && w_rk_ready;
            tick;
            n++;
            if (consume) ptr++;
        end
        total++;
        if (n >= 100 || ptr != 4 || w_round_idx !== 3'd4)
            $display("FAIL w_rounds: got keys=%0d idx=%0d expected 4", ptr, w_round_idx);
        else pass_cnt++;
        result = w_out_data;
        w_out_ready = 1'b1;
        tick;
        w_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_rst = 1'b1;
        #1;
        total++;
        if (a_in_ready !== 1'b0 || s_in_ready !== 1'b0 || w_in_ready !== 1'b0)
            $display("FAIL reset_in_ready: got %b%b%b expected 000", a_in_ready, s_in_ready, w_in_ready);
        else pass_cnt++;
        tick;
        tick;
        total++;
        if (a_in_ready !== 1'b0 || a_rk_ready !== 1'b0)
            $display("FAIL reset_hold: got ir=%b rr=%b expected 0 0", a_in_ready, a_rk_ready);
        else pass_cnt++;
        rst = 1'b0;
        a_rst = 1'b0;
        #1;
        total++;
        if (a_in_ready !== 1'b1 || a_rk_ready !== 1'b0 || a_out_valid !== 1'b0 ||
            a_out_data !== 32'd0 || a_round_idx !== 4'd0)
            $display("FAIL reset_vals: got ir=%b rr=%b ov=%b od=%h ri=%0d expected 1 0 0 0 0",
                     a_in_ready, a_rk_ready, a_out_valid, a_out_data, a_round_idx);
        else pass_cnt++;
        total++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || w_in_ready !== 1'b1 ||
            w_out_valid !== 1'b0 || w_out_data !== 64'd0)
            $display("FAIL reset_vals_sw: got %b %b %b %b %h expected 1 0 1 0 0",
                     s_in_ready, s_out_valid, w_in_ready, w_out_valid, w_out_data);
        else pass_cnt++;
    endtask

    task automatic test_single_round;
        logic [63:0] kk[8];
        logic [31:0] d;
        logic [31:0] exp;
        logic m;
        int lat;
        for (int b = 0; b < 5; b++) begin
            d = (b == 0) ? 32'h0 : $urandom;
            m = (b == 0) ? 1'b0 : 1'(b % 2);
            for (int n = 0; n < 8; n++) kk[n] = 64'd0;
            kk[0] = (b == 0) ? 64'h01020304 : 64'($urandom);
            exp = (b == 0) ? 32'h20200604 : 32'(model_block(64'(d), m, kk, 4, 1, rot4));
            s_in_valid = 1'b1;
            s_in_data  = d;
            s_in_mode  = m;
            s_rk_valid = 1'b1;
            s_rk_data  = kk[0][31:0];
            s_out_ready = 1'b0;
            tick;
            s_in_valid = 1'b0;
            s_in_data  = 32'hFFFFFFFF;
            lat = 0;
            while (!s_out_valid && lat < 20) begin tick; lat++; end
            total++;
            if (lat != 1) $display("FAIL r1_latency: got %0d expected 1", lat);
            else pass_cnt++;
            total++;
            if (s_out_data !== exp || s_round_idx !== 1'b1)
                $display("FAIL r1_data: got %h idx=%0d expected %h idx=1", s_out_data, s_round_idx, exp);
            else pass_cnt++;
            total++;
            if (s_rk_ready !== 1'b0) $display("FAIL r1_rk_done: got %b expected 0", s_rk_ready);
            else pass_cnt++;
            s_out_ready = 1'b1;
            tick;
            s_out_ready = 1'b0;
            s_rk_valid  = 1'b0;
        end
    endtask

    task automatic test_roundtrip;
        logic [63:0] kk[8];
        logic [63:0] kr[8];
        logic [31:0] c;
        logic [31:0] p;
        logic [31:0] exp;
        int lat;
        for (int n = 0; n < 8; n++) kk[n] = 64'(32'h11111111 * (n + 1));
        for (int n = 0; n < 8; n++) kr[n] = kk[7 - n];
        exp = 32'(model_block(64'hDEADBEEF, 1'b0, kk, 4, 8, rot4));
        r8_run(32'hDEADBEEF, 1'b0, kk, -1, 0, 0, c, lat);
        total++;
        if (c !== exp || lat != 8) $display("FAIL rt_enc: got %h lat=%0d expected %h lat=8", c, lat, exp);
        else pass_cnt++;
        r8_run(c, 1'b1, kr, -1, 0, 0, p, lat);
        total++;
        if (p !== 32'hDEADBEEF || lat != 8)
            $display("FAIL rt_dec: got %h lat=%0d expected deadbeef lat=8", p, lat);
        else pass_cnt++;
    endtask

    task automatic test_stall_backpressure;
        logic [63:0] kk[8];
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] exp;
        int lat;
        for (int n = 0; n < 8; n++) kk[n] = 64'($urandom);
        d = $urandom;
        exp = 32'(model_block(64'(d), 1'b0, kk, 4, 8, rot4));
        r8_run(d, 1'b0, kk, 3, 3, 5, c, lat);
        total++;
        if (c !== exp || lat != 11) $display("FAIL stall: got %h lat=%0d expected %h lat=11", c, lat, exp);
        else pass_cnt++;
    endtask

    task automatic test_busy;
        logic [63:0] kk[8];
        logic [63:0] k2[8];
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int lat;
        for (int n = 0; n < 8; n++) begin kk[n] = 64'($urandom); k2[n] = 64'($urandom); end
        a = $urandom;
        b = $urandom;
        a_in_valid = 1'b1;
        a_in_data  = a;
        a_in_mode  = 1'b0;
        a_out_ready = 1'b0;
        tick;
        r8_finish(kk, -1, 0, 1'b1, lat);
        exp = 32'(model_block(64'(a), 1'b0, kk, 4, 8, rot4));
        total++;
        if (a_out_data !== exp) $display("FAIL busy_first: got %h expected %h", a_out_data, exp);
        else pass_cnt++;
        for (int h = 0; h < 2; h++) begin
            a_in_data = $urandom;
            tick;
            total++;
            if (a_in_ready !== 1'b0 || a_out_data !== exp)
                $display("FAIL busy_done: got ir=%b d=%h expected 0 %h", a_in_ready, a_out_data, exp);
            else pass_cnt++;
        end
        a_in_data   = b;
        a_in_mode   = 1'b1;
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_round_idx !== 4'd8)
            $display("FAIL busy_bubble: got ov=%b ir=%b ri=%0d expected 0 1 8",
                     a_out_valid, a_in_ready, a_round_idx);
        else pass_cnt++;
        tick;
        a_in_valid = 1'b0;
        total++;
        if (a_in_ready !== 1'b0 || a_round_idx !== 4'd0)
            $display("FAIL busy_accept2: got ir=%b ri=%0d expected 0 0", a_in_ready, a_round_idx);
        else pass_cnt++;
        r8_finish(k2, -1, 0, 1'b0, lat);
        exp = 32'(model_block(64'(b), 1'b1, k2, 4, 8, rot4));
        total++;
        if (a_out_data !== exp || lat != 8)
            $display("FAIL busy_second: got %h lat=%0d expected %h lat=8", a_out_data, lat, exp);
        else pass_cnt++;
        a_out_ready = 1'b1;
        tick;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [63:0] kk[8];
        logic [31:0] d;
        logic [31:0] c;
        logic [31:0] exp;
        int lat;
        for (int n = 0; n < 8; n++) kk[n] = 64'($urandom);
        a_in_valid = 1'b1;
        a_in_data  = $urandom;
        a_in_mode  = 1'b0;
        tick;
        a_in_valid = 1'b0;
        for (int n = 0; n < 3; n++) begin
            a_rk_valid = 1'b1;
            a_rk_data  = kk[n][31:0];
            tick;
        end
        total++;
        if (a_round_idx !== 4'd3) $display("FAIL rstmid_pre: got %0d expected 3", a_round_idx);
        else pass_cnt++;
        a_rst = 1'b1;
        #1;
        total++;
        if (a_rk_ready !== 1'b0) $display("FAIL rstmid_rk: got %b expected 0", a_rk_ready);
        else pass_cnt++;
        tick;
        a_rst = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_round_idx !== 4'd0 || a_rk_ready !== 1'b0 ||
            a_in_ready !== 1'b1 || a_out_data !== 32'd0)
            $display("FAIL rstmid_post: got ov=%b ri=%0d rr=%b ir=%b od=%h expected 0 0 0 1 0",
                     a_out_valid, a_round_idx, a_rk_ready, a_in_ready, a_out_data);
        else pass_cnt++;
        d = $urandom;
        exp = 32'(model_block(64'(d), 1'b0, kk, 4, 8, rot4));
        r8_run(d, 1'b0, kk, -1, 0, 0, c, lat);
        total++;
        if (c !== exp || lat != 8) $display("FAIL rstmid_fresh: got %h lat=%0d expected %h lat=8", c, lat, exp);
        else pass_cnt++;
    endtask

    task automatic test_wide;
        logic [63:0] kk[8];
        logic [63:0] kr[8];
        logic [63:0] d;
        logic [63:0] c;
        logic [63:0] p;
        logic [63:0] exp;
        for (int blkn = 0; blkn < 1000; blkn++) begin
            d = {$urandom, $urandom};
            for (int n = 0; n < 8; n++) kk[n] = {$urandom, $urandom};
            for (int n = 0; n < 8; n++) kr[n] = (n < 4) ? kk[3 - n] : 64'd0;
            exp = model_block(d, 1'b0, kk, 8, 4, rotw);
            w_run(d, 1'b0, kk, c);
            total++;
            if (c !== exp) $display("FAIL wide_enc: got %h expected %h", c, exp);
            else pass_cnt++;
            exp = model_block(c, 1'b1, kr, 8, 4, rotw);
            w_run(c, 1'b1, kr, p);
            total++;
            if (p !== exp) $display("FAIL wide_dec: got %h expected %h", p, exp);
            else pass_cnt++;
            total++;
            if (p !== d) $display("FAIL wide_identity: got %h expected %h", p, d);
            else pass_cnt++;
        end
    endtask

    initial begin
        a_rst = 1'b1; rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_rk_valid = 1'b1;
        a_rk_data = '0; a_out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_in_mode = 1'b0; s_rk_valid = 1'b1;
        s_rk_data = '0; s_out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_data = '0; w_in_mode = 1'b0; w_rk_valid = 1'b1;
        w_rk_data = '0; w_out_ready = 1'b0;
        test_reset;
        test_single_round;
        test_roundtrip;
        test_stall_backpressure;
        test_busy;
        test_reset_mid;
        test_wide;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
